// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control unit for a multi-cycle CPU.
// Sequences each instruction through IF/ID/EXE/MEM/WB states and drives the
// datapath muxes, the write enables and the 3-bit ALUOp. Branches resolve in
// EXE_BR from the ALU Zero flag.
//
// Ports:
//   CLK, Reset        rising-edge clock, synchronous active-high reset
//   opcode[5:0]       IR[31:26], stable from the cycle after IF
//   Zero              ALU zero flag
//   PCWre, PCSrc[1:0] PC write enable / next-PC select (00 +4, 01 branch, 10 jump)
//   IRWre, InsMemRW   instruction register write, instruction memory read
//   ALUSrcA/B, ALUOp  ALU operand selects and operation
//   ExtSel            0 zero-extend, 1 sign-extend
//   RegDst, RegWre    register file destination select and write enable
//   DBDataSrc         write-back source (0 ALU, 1 memory)
//   mRD, mWR          data memory read / write
//   halted            high while in HALT
//
// Outputs are combinational from state, opcode and Zero, and are all forced
// low while Reset is high.
//
// Build option: define CTRL_BNE_EN to decode opcode 110101 as bne.

module multi_cycle_ctrl (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       Zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       RegDst,
  output logic       RegWre,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic       halted
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned PCSRC_W = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OP_W-1:0] OP_SLL  = 6'b011000;
  localparam logic [OP_W-1:0] OP_SLT  = 6'b100110;
  localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
`ifdef CTRL_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE  = 6'b110101;
`endif
  localparam logic [OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b101;

  localparam logic [PCSRC_W-1:0] PC_PLUS4  = 2'b00;
  localparam logic [PCSRC_W-1:0] PC_BRANCH = 2'b01;
  localparam logic [PCSRC_W-1:0] PC_JUMP   = 2'b10;

  // Nine states do not fit in three bits, so the register is four bits wide.
  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EXE_AL  = 4'd2,
    S_WB_AL   = 4'd3,
    S_EXE_BR  = 4'd4,
    S_EXE_MEM = 4'd5,
    S_MEM     = 4'd6,
    S_WB_LD   = 4'd7,
    S_HALT    = 4'd8
  } state_t;

  state_t state_q, state_d;

  logic                is_rtype, is_imm, is_sw, is_lw, is_br, is_bne, is_j, is_halt;
  logic [ALUOP_W-1:0]  dec_alu_op;
  logic                dec_src_a, dec_src_b, dec_ext;

  // Opcode decode: instruction class plus EXE-stage ALU controls.
  always_comb begin
    is_rtype   = 1'b0;
    is_imm     = 1'b0;
    is_sw      = 1'b0;
    is_lw      = 1'b0;
    is_br      = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    is_halt    = 1'b0;
    dec_alu_op = ALU_ADD;
    dec_src_a  = 1'b0;
    dec_src_b  = 1'b0;
    dec_ext    = 1'b0;
    case (opcode)
      OP_ADD:  is_rtype = 1'b1;
      OP_SUB:  begin is_rtype = 1'b1; dec_alu_op = ALU_SUB; end
      OP_OR:   begin is_rtype = 1'b1; dec_alu_op = ALU_OR;  end
      OP_AND:  begin is_rtype = 1'b1; dec_alu_op = ALU_AND; end
      OP_SLT:  begin is_rtype = 1'b1; dec_alu_op = ALU_SLT; end
      OP_SLL:  begin is_rtype = 1'b1; dec_alu_op = ALU_SLL; dec_src_a = 1'b1; end
      OP_ADDI: begin is_imm = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b1; end
      OP_ORI:  begin is_imm = 1'b1; dec_src_b = 1'b1; dec_alu_op = ALU_OR; end
      OP_SW:   is_sw = 1'b1;
      OP_LW:   is_lw = 1'b1;
      OP_BEQ:  is_br = 1'b1;
`ifdef CTRL_BNE_EN
      OP_BNE:  begin is_br = 1'b1; is_bne = 1'b1; end
`endif
      OP_J:    is_j = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // State register; Reset returns to IF from any state, including HALT.
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next state and control outputs.
  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    PCSrc     = PC_PLUS4;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    RegDst    = 1'b0;
    RegWre    = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (is_j) begin
          PCWre   = 1'b1;
          PCSrc   = PC_JUMP;
          state_d = S_IF;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (is_br) begin
          state_d = S_EXE_BR;
        end else if (is_sw || is_lw) begin
          state_d = S_EXE_MEM;
        end else if (is_rtype || is_imm) begin
          state_d = S_EXE_AL;
        end else begin
          // Unrecognised opcode retires as a nop.
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end
      S_EXE_AL: begin
        ALUOp   = dec_alu_op;
        ALUSrcA = dec_src_a;
        ALUSrcB = dec_src_b;
        ExtSel  = dec_ext;
        state_d = S_WB_AL;
      end
      S_WB_AL: begin
        RegWre  = 1'b1;
        RegDst  = is_rtype;
        PCWre   = 1'b1;
        state_d = S_IF;
      end
      S_EXE_BR: begin
        // bne inverts the sense of Zero.
        ALUOp   = ALU_SUB;
        PCWre   = 1'b1;
        PCSrc   = (Zero ^ is_bne) ? PC_BRANCH : PC_PLUS4;
        state_d = S_IF;
      end
      S_EXE_MEM: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        state_d = S_MEM;
      end
      S_MEM: begin
        if (is_sw) begin
          mWR     = 1'b1;
          PCWre   = 1'b1;
          state_d = S_IF;
        end else begin
          mRD     = 1'b1;
          state_d = S_WB_LD;
        end
      end
      S_WB_LD: begin
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
        PCWre     = 1'b1;
        state_d   = S_IF;
      end
      S_HALT: begin
        halted  = 1'b1;
      end
      default: state_d = S_IF;
    endcase

    // Every control is held inactive while Reset is asserted.
    if (Reset) begin
      PCWre     = 1'b0;
      PCSrc     = PC_PLUS4;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALU_ADD;
      ExtSel    = 1'b0;
      RegDst    = 1'b0;
      RegWre    = 1'b0;
      DBDataSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// Output vector order: {PCWre, PCSrc, IRWre, InsMemRW, ALUSrcA, ALUSrcB,
// ALUOp, ExtSel, RegDst, RegWre, DBDataSrc, mRD, mWR, halted}.

module tb_multi_cycle_ctrl;

  logic       CLK;
  logic       Reset;
  logic [5:0] opcode;
  logic       Zero;
  logic       PCWre;
  logic [1:0] PCSrc;
  logic       IRWre;
  logic       InsMemRW;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic [2:0] ALUOp;
  logic       ExtSel;
  logic       RegDst;
  logic       RegWre;
  logic       DBDataSrc;
  logic       mRD;
  logic       mWR;
  logic       halted;

  logic [16:0] outs;
  int n_cmp = 0;
  int n_err = 0;

  multi_cycle_ctrl dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .opcode    (opcode),
    .Zero      (Zero),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ExtSel    (ExtSel),
    .RegDst    (RegDst),
    .RegWre    (RegWre),
    .DBDataSrc (DBDataSrc),
    .mRD       (mRD),
    .mWR       (mWR),
    .halted    (halted)
  );

  assign outs = {PCWre, PCSrc, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp,
                 ExtSel, RegDst, RegWre, DBDataSrc, mRD, mWR, halted};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [16:0] e(
    input logic pcw, input logic [1:0] pcs, input logic irw, input logic ins,
    input logic asa, input logic asb, input logic [2:0] op, input logic ext,
    input logic rd, input logic rw, input logic db, input logic mrd,
    input logic mwr, input logic hlt);
    return {pcw, pcs, irw, ins, asa, asb, op, ext, rd, rw, db, mrd, mwr, hlt};
  endfunction

  // Check one cycle on the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [16:0] exp);
    @(negedge CLK);
    n_cmp++;
    assert (outs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", tag, outs, exp);
      end
    @(posedge CLK);
    #1;
  endtask

  logic [16:0] E_ZERO, E_IF, E_WB_R, E_WB_I;

  initial begin
    E_ZERO = '0;
    E_IF   = e(0, 2'b00, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    E_WB_R = e(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 0, 0);
    E_WB_I = e(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0);

    Reset  = 1'b1;
    opcode = 6'b000000;
    Zero   = 1'b0;
    @(posedge CLK); #1;

    // Reset held: everything low.
    cyc("rst0", E_ZERO);
    cyc("rst1", E_ZERO);
    cyc("rst2", E_ZERO);
    Reset = 1'b0;

    // add
    cyc("add_if", E_IF);
    cyc("add_id", E_ZERO);
    cyc("add_exe", E_ZERO);
    cyc("add_wb", E_WB_R);

    // sub
    opcode = 6'b000001;
    cyc("sub_if", E_IF);
    cyc("sub_id", E_ZERO);
    cyc("sub_exe", e(0, 2'b00, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0));
    cyc("sub_wb", E_WB_R);

    // addi: sign-extended immediate, writes rt
    opcode = 6'b000010;
    cyc("addi_if", E_IF);
    cyc("addi_id", E_ZERO);
    cyc("addi_exe", e(0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 0));
    cyc("addi_wb", E_WB_I);

    // ori: zero-extended immediate
    opcode = 6'b010010;
    cyc("ori_if", E_IF);
    cyc("ori_id", E_ZERO);
    cyc("ori_exe", e(0, 2'b00, 0, 0, 0, 1, 3'b011, 0, 0, 0, 0, 0, 0, 0));
    cyc("ori_wb", E_WB_I);

    // sll: shamt on A
    opcode = 6'b011000;
    cyc("sll_if", E_IF);
    cyc("sll_id", E_ZERO);
    cyc("sll_exe", e(0, 2'b00, 0, 0, 1, 0, 3'b101, 0, 0, 0, 0, 0, 0, 0));
    cyc("sll_wb", E_WB_R);

    // slt / and / or: EXE ALUOp only
    opcode = 6'b100110;
    cyc("slt_if", E_IF);
    cyc("slt_id", E_ZERO);
    cyc("slt_exe", e(0, 2'b00, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0));
    cyc("slt_wb", E_WB_R);
    opcode = 6'b010001;
    cyc("and_if", E_IF);
    cyc("and_id", E_ZERO);
    cyc("and_exe", e(0, 2'b00, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0));
    cyc("and_wb", E_WB_R);
    opcode = 6'b010000;
    cyc("or_if", E_IF);
    cyc("or_id", E_ZERO);
    cyc("or_exe", e(0, 2'b00, 0, 0, 0, 0, 3'b011, 0, 0, 0, 0, 0, 0, 0));
    cyc("or_wb", E_WB_R);

    // lw: 5 cycles
    opcode = 6'b110001;
    cyc("lw_if", E_IF);
    cyc("lw_id", E_ZERO);
    cyc("lw_exe", e(0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 0));
    cyc("lw_mem", e(0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0));
    cyc("lw_wb", e(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, 1, 0, 0, 0));

    // sw: 4 cycles, no RegWre
    opcode = 6'b110000;
    cyc("sw_if", E_IF);
    cyc("sw_id", E_ZERO);
    cyc("sw_exe", e(0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 0));
    cyc("sw_mem", e(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0));

    // beq taken / not taken
    opcode = 6'b110100;
    Zero   = 1'b1;
    cyc("beq1_if", E_IF);
    cyc("beq1_id", E_ZERO);
    cyc("beq1_exe", e(1, 2'b01, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0));
    Zero   = 1'b0;
    cyc("beq0_if", E_IF);
    cyc("beq0_id", E_ZERO);
    cyc("beq0_exe", e(1, 2'b00, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0));

    // j: PC write in ID
    opcode = 6'b111000;
    cyc("j_if", E_IF);
    cyc("j_id", e(1, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));

    // 110101 with Zero=0
    opcode = 6'b110101;
    Zero   = 1'b0;
    cyc("bne_if", E_IF);
`ifdef CTRL_BNE_EN
    cyc("bne_id", E_ZERO);
    cyc("bne_exe", e(1, 2'b01, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0));
`else
    cyc("bne_nop_id", e(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
`endif

    // unknown opcode: 2-cycle nop
    opcode = 6'b001111;
    cyc("unk_if", E_IF);
    cyc("unk_id", e(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));

    // halt: stays halted, no PCWre
    opcode = 6'b111111;
    cyc("halt_if", E_IF);
    cyc("halt_id", E_ZERO);
    for (int i = 0; i < 20; i++)
      cyc("halt_hold", e(0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1));
    Reset = 1'b1;
    cyc("halt_rst", E_ZERO);
    Reset  = 1'b0;
    opcode = 6'b110000;
    cyc("halt_rst_if", E_IF);

    // sw interrupted by reset in MEM
    cyc("swr_id", E_ZERO);
    cyc("swr_exe", e(0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 0));
    Reset = 1'b1;
    cyc("swr_mem_rst", E_ZERO);
    Reset = 1'b0;
    cyc("swr_if", E_IF);
    cyc("swr_id2", E_ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
